// File: rtl/fifo_scoreboard.sv
// fifo_scoreboard: passive checker for a FIFO. A reference model tracks
// the writes and reads it sees and checks data_out against them.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, clear   IDLE->RUN pulse; sync clear of model, counters, FSM
//   wr_en, rd_en   enables seen at the monitored FIFO input
//   data_in        write data seen at the FIFO input
//   data_out       FIFO read data, one cycle after an accepted read
//   full, empty    FIFO status flags (checked only with the macro)
//   error_count    saturating mismatch counter
//   correct_count  saturating matching-compare counter
//   mismatch       one-cycle pulse on any counted mismatch
//   test_finished  high while the FSM is in DONE
//
// Optional: define FIFO_SCOREBOARD_FLAG_CHECK_EN to also check full/empty
// against the model occupancy every RUN cycle.

module fifo_scoreboard #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = 64,
    parameter int TXN_TARGET = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  full,
    input  logic                  empty,
    output logic [COUNT_W-1:0]    error_count,
    output logic [COUNT_W-1:0]    correct_count,
    output logic                  mismatch,
    output logic                  test_finished
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(FIFO_DEPTH);

    // Private compare counter so flag errors never advance the target
    localparam int TXN_W =
        (TXN_TARGET < 1) ? 1 : $clog2(TXN_TARGET + 1);
    localparam logic [TXN_W-1:0] TARGET_T = TXN_W'(TXN_TARGET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  cmp_pending;
    logic [FIFO_WIDTH-1:0] exp_data;
    logic [TXN_W-1:0]      txn_cnt;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  in_run;
    logic                  cmp_fire;
    logic                  data_err;
    logic [1:0]            flag_err;
    logic [1:0]            err_inc;
    logic [COUNT_W-1:0]    err_nxt;
    logic [COUNT_W-1:0]    ok_nxt;
    logic [TXN_W-1:0]      txn_nxt;

    function automatic logic [COUNT_W-1:0] sat_add(
        input logic [COUNT_W-1:0] a,
        input logic [1:0]         b
    );
        logic [COUNT_W:0] s;
        s = {1'b0, a} + (COUNT_W + 1)'(b);
        return s[COUNT_W] ? '1 : s[COUNT_W-1:0];
    endfunction

    assign wr_ok    = wr_en && (occ != DEPTH_O);
    assign rd_ok    = rd_en && (occ != '0);
    assign in_run   = (state == RUN);
    assign cmp_fire = in_run && cmp_pending;
    assign data_err = cmp_fire && (data_out != exp_data);

`ifdef FIFO_SCOREBOARD_FLAG_CHECK_EN
    logic full_bad;
    logic empty_bad;
    assign full_bad  = in_run && (full != (occ == DEPTH_O));
    assign empty_bad = in_run && (empty != (occ == '0));
    assign flag_err  = {1'b0, full_bad} + {1'b0, empty_bad};
`else
    logic unused_flags;
    assign unused_flags = full ^ empty;
    assign flag_err     = 2'b00;
`endif

    assign err_inc = {1'b0, data_err} + flag_err;
    assign err_nxt = sat_add(error_count, err_inc);
    assign ok_nxt  = (cmp_fire && !data_err)
                   ? sat_add(correct_count, 2'd1)
                   : correct_count;
    assign txn_nxt = txn_cnt
                   + TXN_W'(cmp_fire && (txn_cnt != TARGET_T));

    // Model storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            cmp_pending   <= 1'b0;
            exp_data      <= '0;
            txn_cnt       <= '0;
            error_count   <= '0;
            correct_count <= '0;
            mismatch      <= 1'b0;
            test_finished <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            cmp_pending   <= 1'b0;
            txn_cnt       <= '0;
            error_count   <= '0;
            correct_count <= '0;
            mismatch      <= 1'b0;
            test_finished <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                exp_data <= mem[rd_ptr];
            end
            unique case (1'b1)
                wr_ok && !rd_ok: occ <= occ + 1'b1;
                rd_ok && !wr_ok: occ <= occ - 1'b1;
                default:         occ <= occ;
            endcase
            cmp_pending <= rd_ok;
            // err_inc is already zero outside RUN
            mismatch    <= (err_inc != 2'b00);
            if (in_run) begin
                error_count   <= err_nxt;
                correct_count <= ok_nxt;
                txn_cnt       <= txn_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (txn_nxt == TARGET_T) begin
                        state         <= DONE;
                        test_finished <= 1'b1;
                    end
                end
                DONE: begin
                    test_finished <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    test_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_scoreboard.md
FIFO_SCOREBOARD -- requirements
Module: fifo_scoreboard

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data width of the monitored FIFO.
REQ-002 Parameter FIFO_DEPTH, default 8, depth of the monitored FIFO (power of two).
REQ-003 Parameter COUNT_W, default 64, width of the error and correct counters.
REQ-004 Parameter TXN_TARGET, default 1000, number of data compares after which the test finishes.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle pulse; IDLE -> RUN.
REQ-008 clear  input  1  synchronous clear of counters, model and FSM.
REQ-009 wr_en  input  1  write enable observed at the FIFO input.
REQ-010 rd_en  input  1  read enable observed at the FIFO input.
REQ-011 data_in  input  FIFO_WIDTH  write data observed at the FIFO input.
REQ-012 data_out  input  FIFO_WIDTH  FIFO read data, valid one cycle after an accepted read.
REQ-013 full, empty  input  1 each  FIFO status flags.
REQ-014 error_count  output  COUNT_W  number of mismatches.
REQ-015 correct_count  output  COUNT_W  number of matching data compares.
REQ-016 mismatch  output  1  one-cycle pulse on any counted mismatch.
REQ-017 test_finished  output  1  high while the FSM is in DONE.

Function
REQ-018 Reference model SHALL be a FIFO_DEPTH x FIFO_WIDTH memory with wr_ptr, rd_ptr (log2 FIFO_DEPTH bits, wrap modulo depth) and occupancy count (log2 FIFO_DEPTH + 1 bits).
REQ-019 Model write accepted iff wr_en and occupancy != FIFO_DEPTH, evaluated on pre-edge occupancy.
REQ-020 Model read accepted iff rd_en and occupancy != 0, evaluated on pre-edge occupancy.
REQ-021 Simultaneous accepted read and write: occupancy unchanged, both pointers advance.
REQ-022 rd_en and wr_en on an empty model: only the write is accepted. On a full model: only the read is accepted.
REQ-023 Accepted read SHALL latch the expected word and set cmp_pending; the next cycle compares data_out against it (latency 1).
REQ-024 Model updates in every FSM state; compares and counters update only in RUN.
REQ-025 In RUN, a compare with data_out == expected increments correct_count; otherwise it increments error_count and pulses mismatch.
REQ-026 Counters SHALL saturate at all-ones and never wrap.
REQ-027 FSM states are IDLE, RUN and DONE. IDLE -> RUN on start. RUN -> DONE in the cycle after (correct_count + error_count from data compares) reaches TXN_TARGET. DONE holds until clear or reset.
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 clear has priority over all other inputs: pointers, occupancy, cmp_pending and counters go to 0, mismatch goes to 0, and the FSM goes to IDLE on the next edge.

Reset
REQ-030 rst_n low asynchronously forces FSM=IDLE, error_count=0, correct_count=0, mismatch=0, test_finished=0, pointers/occupancy=0 and cmp_pending=0.
REQ-031 Reset asserted mid-compare discards the pending compare. The first cycle after rst_n deasserts has no compare.
REQ-032 Model memory contents are not reset.

Configuration
REQ-033 Macro FIFO_SCOREBOARD_FLAG_CHECK_EN.
- Defined: in RUN, every cycle compare full against (occupancy == FIFO_DEPTH) and empty against (occupancy == 0). Each flag mismatch increments error_count by 1 and pulses mismatch. Flag checks do not count toward TXN_TARGET.
- Undefined: full/empty are unused and no flag logic is generated.

Verification
REQ-034 Reset, start, write 0xA5A5, read, data_out=0xA5A5 next cycle -> correct_count=1, error_count=0, mismatch stays 0.
REQ-035 Write 8 words 0..7, then 9th write (0x00FF) plus read of wrong data_out=0x1234 -> 9th write dropped, error_count=1, mismatch pulses once.
REQ-036 Empty model, rd_en=wr_en=1 with data_in=0x0042 -> occupancy 1, no compare; next read returns 0x0042 -> correct_count=1.
REQ-037 TXN_TARGET=4, 4 matching write/read pairs -> test_finished=1 one cycle after the 4th compare. Further start is ignored and test_finished stays 1 until clear.
REQ-038 rst_n dropped the cycle after an accepted read -> counters 0 immediately, no compare after release, FSM=IDLE.
REQ-039 With FIFO_SCOREBOARD_FLAG_CHECK_EN defined, in RUN, empty=0 driven while the model is empty -> error_count increments every cycle and correct_count stays unchanged.
